bcd_seg_counter: RTL and testbench

- Two-digit BCD event counter with a 7-segment encoder.
- Produces the 14-bit packed pattern bus `both7seg` consumed by the downstream two-digit display multiplexer.
  - Tens digit occupies [13:7]; ones digit occupies [6:0].
- The display register updates only on a `latch` strobe, so the multiplexer never sees a half-updated count.

---
 rtl/bcd_seg_counter.sv | 110 +++++++++++
 tb/tb_bcd_seg_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_counter.sv
// Two-digit BCD up/down event counter with a latched 7-segment display register.
// Count, wrap, err and both7seg are all registered (1 cycle); no backpressure, every event is taken.
module bcd_seg_counter #(
  parameter int MAXV       = 99,
  parameter int LZB        = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  load_val,
  input  logic        latch,
  output logic [13:0] both7seg,
  output logic [7:0]  count,
  output logic        wrap,
  output logic        err
);

  localparam logic [3:0]  MAX_T   = 4'(MAXV / 10);
  localparam logic [3:0]  MAX_O   = 4'(MAXV % 10);
  localparam logic [7:0]  MAX_BCD = {MAX_T, MAX_O};
  localparam logic [13:0] SEG_OFF = (ACTIVE_LOW != 0) ? 14'h3FFF : 14'h0000;

  logic [7:0]  count_q, count_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;
  logic [13:0] seg_q, seg_d;
  logic [7:0]  ld_dec;
  logic        ld_ok;
  logic [6:0]  tens_seg;
  logic [13:0] disp;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Decimal value of the load word is only meaningful once both nibbles pass the <=9 test.
  assign ld_dec = {4'd0, load_val[7:4]} * 8'd10 + {4'd0, load_val[3:0]};
  assign ld_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) && (ld_dec <= 8'(MAXV));

  assign tens_seg = ((LZB != 0) && (count_q[7:4] == 4'd0)) ? 7'h00 : seg7(count_q[7:4]);
  assign disp     = (ACTIVE_LOW != 0) ? ~{tens_seg, seg7(count_q[3:0])}
                                      :  {tens_seg, seg7(count_q[3:0])};

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    seg_d   = latch ? disp : seg_q;
    if (clr) begin
      count_d = 8'h00;
    end else if (load) begin
      if (ld_ok) count_d = load_val;
      else       err_d   = 1'b1;
    end else if (inc && !dec) begin
      if (count_q == MAX_BCD) begin
        count_d = 8'h00;
        wrap_d  = 1'b1;
      end else if (count_q[3:0] == 4'd9) begin
        count_d = {count_q[7:4] + 4'd1, 4'd0};
      end else begin
        count_d = {count_q[7:4], count_q[3:0] + 4'd1};
      end
    end else if (dec && !inc) begin
      if (count_q == 8'h00) begin
        count_d = MAX_BCD;
        wrap_d  = 1'b1;
      end else if (count_q[3:0] == 4'd0) begin
        count_d = {count_q[7:4] - 4'd1, 4'd9};
      end else begin
        count_d = {count_q[7:4], count_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'h00;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= SEG_OFF;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
    end
  end

  assign both7seg = seg_q;
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Bench for bcd_seg_counter: three parameterisations driven in lockstep, checked every cycle
// against a decimal-integer model plus hand-computed literals.
module tb_bcd_seg_counter;

  localparam int P_MAX [3] = '{99, 59, 99};
  localparam int P_LZB [3] = '{1, 0, 1};
  localparam int P_AL  [3] = '{0, 0, 1};
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst, inc, dec, clr, load, latch;
  logic [7:0] load_val;

  logic [13:0] seg_o [3];
  logic [7:0]  cnt_o [3];
  logic        wrap_o [3];
  logic        err_o [3];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  int          m_cnt  [3];
  logic [13:0] m_disp [3];
  logic        m_wrap [3];
  logic        m_err  [3];

  always #5 clk = ~clk;

  bcd_seg_counter #(.MAXV(99), .LZB(1), .ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .latch(latch), .both7seg(seg_o[0]), .count(cnt_o[0]),
    .wrap(wrap_o[0]), .err(err_o[0]));
  bcd_seg_counter #(.MAXV(59), .LZB(0), .ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .latch(latch), .both7seg(seg_o[1]), .count(cnt_o[1]),
    .wrap(wrap_o[1]), .err(err_o[1]));
  bcd_seg_counter #(.MAXV(99), .LZB(1), .ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .latch(latch), .both7seg(seg_o[2]), .count(cnt_o[2]),
    .wrap(wrap_o[2]), .err(err_o[2]));

  function automatic logic [13:0] menc(input int v, input int lzb, input int al);
    logic [6:0]  tf;
    logic [13:0] r;
    tf = (lzb != 0 && v / 10 == 0) ? 7'h00 : SEG[v / 10];
    r  = {tf, SEG[v % 10]};
    return (al != 0) ? ~r : r;
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: count held as a plain decimal integer.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i]  = 0;
        m_wrap[i] = 1'b0;
        m_err[i]  = 1'b0;
        m_disp[i] = (P_AL[i] != 0) ? 14'h3FFF : 14'h0000;
      end else begin
        int t, o;
        m_wrap[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (latch) m_disp[i] = menc(m_cnt[i], P_LZB[i], P_AL[i]);
        t = int'(load_val[7:4]);
        o = int'(load_val[3:0]);
        if (clr) m_cnt[i] = 0;
        else if (load) begin
          if (t <= 9 && o <= 9 && t * 10 + o <= P_MAX[i]) m_cnt[i] = t * 10 + o;
          else m_err[i] = 1'b1;
        end else if (inc && !dec) begin
          if (m_cnt[i] == P_MAX[i]) begin m_cnt[i] = 0; m_wrap[i] = 1'b1; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else if (dec && !inc) begin
          if (m_cnt[i] == 0) begin m_cnt[i] = P_MAX[i]; m_wrap[i] = 1'b1; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("count[%0d]", i), {6'd0, cnt_o[i]},
            {6'd0, 4'(m_cnt[i] / 10), 4'(m_cnt[i] % 10)});
        chk($sformatf("wrap[%0d]", i), {13'd0, wrap_o[i]}, {13'd0, m_wrap[i]});
        chk($sformatf("err[%0d]", i), {13'd0, err_o[i]}, {13'd0, m_err[i]});
        chk($sformatf("seg[%0d]", i), seg_o[i], m_disp[i]);
      end
    end
  end

  // Applies one cycle of inputs; returns at the next negedge with the results visible.
  task automatic drive(input logic i, input logic d, input logic c, input logic l,
                       input logic [7:0] v, input logic lt);
    inc = i; dec = d; clr = c; load = l; load_val = v; latch = lt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; inc = 0; dec = 0; clr = 0; load = 0; load_val = 8'h00; latch = 0;
    @(negedge clk);
    drive(1, 1, 0, 1, 8'h42, 1);
    drive(0, 0, 0, 0, 8'h00, 0);
    chk("rst_seg_hi", seg_o[2], 14'h3FFF);
    rst = 1'b0;

    drive(0, 0, 0, 0, 8'h00, 1);
    chk("rst_count", {6'd0, cnt_o[0]}, 14'h0000);
    chk("rst_latch", seg_o[0], 14'h003F);
    chk("rst_latch_al", seg_o[2], 14'h3FC0);

    drive(0, 0, 0, 1, 8'h09, 0);
    drive(1, 0, 0, 0, 8'h00, 0);
    chk("carry_count", {6'd0, cnt_o[0]}, 14'h0010);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("carry_seg", seg_o[0], 14'h033F);

    drive(0, 0, 0, 1, 8'h99, 0);
    chk("ld99_ok", {13'd0, err_o[0]}, 14'h0000);
    chk("ld99_rej_m59", {13'd0, err_o[1]}, 14'h0001);
    drive(1, 0, 0, 0, 8'h00, 0);
    chk("upwrap_count", {6'd0, cnt_o[0]}, 14'h0000);
    chk("upwrap_pulse", {13'd0, wrap_o[0]}, 14'h0001);
    drive(0, 0, 0, 0, 8'h00, 0);
    chk("upwrap_end", {13'd0, wrap_o[0]}, 14'h0000);

    drive(0, 1, 0, 0, 8'h00, 0);
    chk("dnwrap_count", {6'd0, cnt_o[0]}, 14'h0099);
    chk("dnwrap_pulse", {13'd0, wrap_o[0]}, 14'h0001);
    drive(1, 1, 0, 0, 8'h00, 0);
    chk("tie_count", {6'd0, cnt_o[0]}, 14'h0099);
    chk("tie_wrap", {13'd0, wrap_o[0]}, 14'h0000);

    drive(0, 0, 0, 1, 8'h3A, 0);
    chk("ld3A_err", {13'd0, err_o[0]}, 14'h0001);
    drive(0, 0, 0, 1, 8'hA1, 0);
    chk("ldA1_err", {13'd0, err_o[0]}, 14'h0001);
    chk("ldA1_count", {6'd0, cnt_o[0]}, 14'h0099);
    drive(0, 0, 0, 1, 8'h60, 0);
    chk("ld60_m59_err", {13'd0, err_o[1]}, 14'h0001);
    chk("ld60_count", {6'd0, cnt_o[0]}, 14'h0060);

    drive(1, 0, 1, 1, 8'h55, 0);
    chk("prio_count", {6'd0, cnt_o[0]}, 14'h0000);
    drive(0, 0, 0, 0, 8'h00, 1);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 8'h00, 0);
    chk("tear_hold", seg_o[0], 14'h003F);
    chk("tear_count", {6'd0, cnt_o[0]}, 14'h0005);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("tear_latch", seg_o[0], 14'h006D);
    chk("tear_latch_nolzb", seg_o[1], 14'h1FED);
    chk("tear_latch_al", seg_o[2], 14'h3F92);

    drive(0, 1, 0, 0, 8'h00, 1);
    chk("latch_pre_update", seg_o[0], 14'h006D);

    rst = 1'b1;
    drive(1, 0, 0, 1, 8'h23, 1);
    rst = 1'b0;
    chk("midrst_count", {6'd0, cnt_o[0]}, 14'h0000);
    chk("midrst_seg", seg_o[0], 14'h0000);
    drive(0, 1, 0, 0, 8'h00, 0);
    chk("dnwrap_m59", {6'd0, cnt_o[1]}, 14'h0059);

    for (int k = 0; k < 130; k++) drive(1, 0, 0, 0, 8'h00, (k % 7) == 0);
    for (int k = 0; k < 130; k++) drive(0, 1, 0, 0, 8'h00, (k % 5) == 0);
    for (int k = 0; k < 60; k++) drive(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                                       ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
    drive(0, 0, 0, 0, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
